// File: rtl/e1_qadd_arbiter.sv
// -----------------------------------------------------------------------------
// e1_qadd_arbiter
//   Shares one E1_qadd fixed-point adder between NREQ requesters. A round-robin
//   arbiter accepts one request at a time. The operands are latched and sent
//   to the adder with a single a_en/b_en pulse. The arbiter then waits for
//   c_valid and returns the sum tagged with the requester id. A wait-cycle
//   timeout guards against a hung adder.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-low
//   req_valid    in   [NREQ]     per-requester request, held until req_ready
//   req_a/req_b  in   [NREQ*W]   operands, requester i at [i*W +: W]
//   req_ready    out  [NREQ]     one-hot single-cycle accept pulse
//   resp_valid   out             single-cycle result pulse
//   resp_id      out  [IDW]      requester that owns resp_data
//   resp_data    out  [W]        adder sum (0 on timeout)
//   resp_err     out             set together with resp_valid when the op timed out
//   err_sticky   out             set by any timeout, cleared only by reset
//   busy         out             high in every state except IDLE
//   add_a/add_b  out  [W]        operands to the adder, held until the next issue
//   add_a_en/add_b_en out        one-cycle operand strobe to the adder
//   add_c        in   [W]        adder result
//   add_c_valid  in              adder result strobe, ignored outside WAIT
// -----------------------------------------------------------------------------
module e1_qadd_arbiter #(
  parameter int W    = 64,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_data,
  output logic              resp_err,
  output logic              err_sticky,
  output logic              busy,
  output logic [W-1:0]      add_a,
  output logic              add_a_en,
  output logic [W-1:0]      add_b,
  output logic              add_b_en,
  input  logic [W-1:0]      add_c,
  input  logic              add_c_valid
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cur_id;
  logic [CW-1:0]  wait_cnt;

  logic [IDW-1:0]  grant;
  logic            grant_any;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [NREQ-1:0] grant_onehot;

  // Round-robin search: start just after the last served requester and wrap.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!grant_any && req_valid[IDW'((int'(last_grant) + i) % NREQ)]) begin
        grant     = IDW'((int'(last_grant) + i) % NREQ);
        grant_any = 1'b1;
      end
    end
  end

  // Operand slice and one-hot accept vector for the chosen requester.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a           = req_a[i*W +: W];
        sel_b           = req_b[i*W +: W];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Each output is set on the edge that enters its state. The output is then
  // valid for exactly the cycle spent in that state: req_ready and the adder
  // strobes during ISSUE, and resp_valid during DONE.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NREQ - 1);
      cur_id     <= '0;
      wait_cnt   <= '0;
      req_ready  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
      add_a      <= '0;
      add_a_en   <= 1'b0;
      add_b      <= '0;
      add_b_en   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            req_ready <= grant_onehot;
            cur_id    <= grant;
            add_a     <= sel_a;
            add_b     <= sel_b;
            add_a_en  <= 1'b1;
            add_b_en  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          req_ready <= '0;
          add_a_en  <= 1'b0;
          add_b_en  <= 1'b0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // A result arriving on the timeout cycle still wins.
          if (add_c_valid) begin
            resp_data  <= add_c;
            resp_err   <= 1'b0;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end else if (wait_cnt == CW'(TMO - 1)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            err_sticky <= 1'b1;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        S_DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          last_grant <= cur_id;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
